// File: rtl/cluster_axi_to_mem_if.sv
// AXI4 bus bundle between the cluster crossbar and its single-port memory bridges.
// The Master side drives requests and the Slave side drives responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 48,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 10
);
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_valid;
  logic                        aw_ready;

  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic                        w_valid;
  logic                        w_ready;

  logic [AXI_ID_WIDTH-1:0]     b_id;
  logic [1:0]                  b_resp;
  logic [AXI_USER_WIDTH-1:0]   b_user;
  logic                        b_valid;
  logic                        b_ready;

  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_valid;
  logic                        ar_ready;

  logic [AXI_ID_WIDTH-1:0]     r_id;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;
  logic [AXI_USER_WIDTH-1:0]   r_user;
  logic                        r_valid;
  logic                        r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/cluster_axi_to_mem.sv
// AXI4 responder that serialises one burst at a time onto a req/gnt single-port memory.
// Reads and writes alternate when both address channels request in the same cycle.
module cluster_axi_to_mem #(
  parameter int unsigned AXI_ADDR_WIDTH = 48,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  AXI_BUS.Slave                       axi_slave,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic [AXI_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                        mem_we_o,
  output logic [AXI_DATA_WIDTH/8-1:0] mem_be_o,
  output logic [AXI_DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                        mem_rvalid_i,
  input  logic [AXI_DATA_WIDTH-1:0]   mem_rdata_i
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] WORD_MASK = ~(AXI_ADDR_WIDTH'(STRB_W - 1));
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT, RD_RESP} state_e;

  state_e                    state_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q;
  logic [7:0]                cnt_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      prio_rd_q;
  logic                      wr_err_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  function automatic logic burst_ok(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

  logic                      last_beat;
  logic                      bad_burst;
  logic                      grant_wr;
  logic                      grant_rd;
  logic                      w_ready;
  logic                      w_hs;
  logic [AXI_ADDR_WIDTH-1:0] addr_next;

  assign last_beat = (cnt_q == len_q);
  assign bad_burst = !burst_ok(burst_q);
  // Address arithmetic is left to wrap naturally at the top of the address space.
  assign addr_next = (burst_q == BURST_INCR) ? addr_q + (AXI_ADDR_WIDTH'(1) << size_q) : addr_q;
  // prio_rd_q is set after a write grant, so a contested cycle goes to the other channel.
  assign grant_wr  = axi_slave.aw_valid && (!axi_slave.ar_valid || !prio_rd_q);
  assign grant_rd  = axi_slave.ar_valid && (!axi_slave.aw_valid || prio_rd_q);
  assign w_ready   = (state_q == WR_DATA) && (bad_burst || mem_gnt_i);
  assign w_hs      = axi_slave.w_valid && w_ready;

  always_comb begin
    axi_slave.aw_ready = (state_q == IDLE) && grant_wr;
    axi_slave.ar_ready = (state_q == IDLE) && grant_rd;
    axi_slave.w_ready  = w_ready;

    axi_slave.b_valid  = (state_q == WR_RESP);
    axi_slave.b_id     = (state_q == WR_RESP) ? id_q : '0;
    axi_slave.b_resp   = ((state_q == WR_RESP) && (bad_burst || wr_err_q)) ? RESP_SLVERR : RESP_OKAY;
    axi_slave.b_user   = '0;

    axi_slave.r_valid  = (state_q == RD_RESP);
    axi_slave.r_data   = (state_q == RD_RESP) ? rdata_q : '0;
    axi_slave.r_id     = (state_q == RD_RESP) ? id_q : '0;
    axi_slave.r_last   = (state_q == RD_RESP) && last_beat;
    axi_slave.r_resp   = ((state_q == RD_RESP) && bad_burst) ? RESP_SLVERR : RESP_OKAY;
    axi_slave.r_user   = '0;

    mem_req_o   = ((state_q == WR_DATA) && !bad_burst && axi_slave.w_valid) || (state_q == RD_REQ);
    mem_we_o    = (state_q == WR_DATA);
    mem_be_o    = (state_q == WR_DATA) ? axi_slave.w_strb : '0;
    mem_wdata_o = (state_q == WR_DATA) ? axi_slave.w_data : '0;
    mem_addr_o  = addr_q & WORD_MASK;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      prio_rd_q <= 1'b0;
      wr_err_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_wr) begin
            id_q      <= axi_slave.aw_id;
            addr_q    <= axi_slave.aw_addr;
            len_q     <= axi_slave.aw_len;
            size_q    <= axi_slave.aw_size;
            burst_q   <= axi_slave.aw_burst;
            cnt_q     <= '0;
            wr_err_q  <= 1'b0;
            prio_rd_q <= 1'b1;
            state_q   <= WR_DATA;
          end else if (grant_rd) begin
            id_q      <= axi_slave.ar_id;
            addr_q    <= axi_slave.ar_addr;
            len_q     <= axi_slave.ar_len;
            size_q    <= axi_slave.ar_size;
            burst_q   <= axi_slave.ar_burst;
            cnt_q     <= '0;
            prio_rd_q <= 1'b0;
            rdata_q   <= '0;
            // Unsupported bursts never touch memory; beats are answered with an error.
            state_q   <= burst_ok(axi_slave.ar_burst) ? RD_REQ : RD_RESP;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            if (axi_slave.w_last != last_beat) wr_err_q <= 1'b1;
            if (last_beat) begin
              state_q <= WR_RESP;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_next;
            end
          end
        end
        WR_RESP: begin
          if (axi_slave.b_ready) state_q <= IDLE;
        end
        RD_REQ: begin
          if (mem_gnt_i) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_q <= mem_rdata_i;
            state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axi_slave.r_ready) begin
            if (last_beat) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= addr_next;
              state_q <= bad_burst ? RD_RESP : RD_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cluster_axi_to_mem.sv
// Randomised bench for cluster_axi_to_mem: a req/gnt memory responder plus a
// burst-level reference model of expected memory accesses and AXI responses.
module tb_cluster_axi_to_mem;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int IW = 6;
  localparam int UW = 10;
  localparam int SW = DW / 8;
  localparam int OFFS = $clog2(SW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_wdata, mem_rdata;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)) axi ();

  cluster_axi_to_mem #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi_slave(axi),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- memory models ----------------
  typedef struct {logic [AW-1:0] addr; logic [SW-1:0] be; logic [DW-1:0] data; logic we;} acc_t;
  acc_t          obs_q[$];
  logic [DW-1:0] mem     [logic [AW-1:0]];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            req_cycles = 0;
  int            gnt_pct    = 70;
  int            lat_fixed  = 0;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {~a[31:0], a[31:0]};
  endfunction
  function automatic logic [DW-1:0] mem_get(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction
  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  initial begin
    int            lat_cnt;
    bit            grant_now;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] w;
    lat_cnt = 0; rd_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      grant_now = 1'b0;
      if (!rst) begin
        if (mem_req) req_cycles++;
        if (mem_req && mem_gnt) begin
          obs_q.push_back('{mem_addr, mem_be, mem_wdata, mem_we});
          if (mem_we) begin
            w = mem_get(mem_addr);
            for (int b = 0; b < SW; b++) if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem[mem_addr] = w;
          end else begin
            rd_addr = mem_addr;
            grant_now = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_gnt = ($urandom_range(0, 99) < gnt_pct);
      if (rst) lat_cnt = 0;
      else if (grant_now) lat_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_get(rd_addr);
        end
      end else if (!rst && $urandom_range(0, 9) == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {$urandom(), $urandom()};
      end
    end
  end

  // ---------------- transaction description and reference ----------------
  logic [IW-1:0] t_id;
  logic [AW-1:0] t_addr;
  logic [7:0]    t_len;
  logic [2:0]    t_size;
  logic [1:0]    t_burst;
  int            t_err_beat;
  logic [DW-1:0] t_wdata [256];
  logic [SW-1:0] t_strb  [256];
  bit            pref_rd = 1'b0;

  function automatic logic [AW-1:0] word_addr(input int i);
    logic [AW-1:0] a;
    a = (t_burst == 2'b00) ? t_addr : t_addr + (AW'(i) << t_size);
    return (a >> OFFS) << OFFS;
  endfunction

  function automatic bit t_bad();
    return t_burst > 2'b01;
  endfunction

  task automatic prep_wdata();
    for (int i = 0; i <= int'(t_len); i++) begin
      t_wdata[i] = {$urandom(), $urandom()};
      t_strb[i]  = SW'($urandom());
    end
  endtask

  task automatic set_aw();
    axi.aw_id = t_id; axi.aw_addr = t_addr; axi.aw_len = t_len;
    axi.aw_size = t_size; axi.aw_burst = t_burst;
  endtask

  task automatic set_ar();
    axi.ar_id = t_id; axi.ar_addr = t_addr; axi.ar_len = t_len;
    axi.ar_size = t_size; axi.ar_burst = t_burst;
  endtask

  task automatic addr_phase(output int which);
    which = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (axi.aw_valid && axi.aw_ready) which = 1;
      else if (axi.ar_valid && axi.ar_ready) which = 2;
      @(posedge clk);
      #1;
      if (which == 1) axi.aw_valid = 1'b0;
      if (which == 2) axi.ar_valid = 1'b0;
      if (which != 0) break;
    end
    if (which == 0) check_eq("addr_timeout", 0, 1);
  endtask

  task automatic finish_write();
    bit            ok;
    int            exp_n;
    logic [DW-1:0] w;
    for (int i = 0; i <= int'(t_len); i++) begin
      axi.w_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      axi.w_data = t_wdata[i]; axi.w_strb = t_strb[i];
      axi.w_last = (i == int'(t_len)) ^ (i == t_err_beat);
      axi.w_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (axi.w_ready) ok = 1'b1;
        @(posedge clk);
        #1;
        if (ok) break;
      end
      if (!ok) check_eq("w_timeout", 0, 1);
    end
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (axi.b_valid && axi.b_ready) begin
        ok = 1'b1;
        check_eq("b_resp", axi.b_resp, (t_bad() || t_err_beat >= 0) ? 2'b10 : 2'b00);
        check_eq("b_id", axi.b_id, t_id);
        check_eq("b_user", axi.b_user, 0);
      end
      @(posedge clk);
      #1;
      axi.b_ready = ($urandom_range(0, 2) != 0);
      if (ok) break;
    end
    axi.b_ready = 1'b0;
    if (!ok) check_eq("b_timeout", 0, 1);
    exp_n = t_bad() ? 0 : int'(t_len) + 1;
    check_eq("wr_count", obs_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < obs_q.size(); i++) begin
      check_eq("wr_addr", obs_q[i].addr, word_addr(i));
      check_eq("wr_be", obs_q[i].be, t_strb[i]);
      check_eq("wr_data", obs_q[i].data, t_wdata[i]);
      check_eq("wr_we", obs_q[i].we, 1);
    end
    for (int i = 0; i < exp_n; i++) begin
      w = ref_get(word_addr(i));
      for (int b = 0; b < SW; b++) if (t_strb[i][b]) w[b*8 +: 8] = t_wdata[i][b*8 +: 8];
      ref_mem[word_addr(i)] = w;
    end
  endtask

  task automatic finish_read();
    bit ok;
    int exp_n;
    for (int i = 0; i <= int'(t_len); i++) begin
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (axi.r_valid && axi.r_ready) begin
          ok = 1'b1;
          if (!t_bad()) check_eq("r_data", axi.r_data, ref_get(word_addr(i)));
          check_eq("r_resp", axi.r_resp, t_bad() ? 2'b10 : 2'b00);
          check_eq("r_last", axi.r_last, i == int'(t_len));
          check_eq("r_id", axi.r_id, t_id);
        end
        @(posedge clk);
        #1;
        axi.r_ready = ($urandom_range(0, 3) != 0);
        if (ok) break;
      end
      if (!ok) check_eq("r_timeout", 0, 1);
    end
    axi.r_ready = 1'b0;
    exp_n = t_bad() ? 0 : int'(t_len) + 1;
    check_eq("rd_count", obs_q.size(), exp_n);
    for (int i = 0; i < exp_n && i < obs_q.size(); i++) begin
      check_eq("rd_addr", obs_q[i].addr, word_addr(i));
      check_eq("rd_we", obs_q[i].we, 0);
    end
  endtask

  task automatic do_write();
    int which;
    obs_q.delete();
    set_aw();
    axi.aw_valid = 1'b1;
    addr_phase(which);
    check_eq("aw_accept", which, 1);
    pref_rd = 1'b1;
    if (which == 1) finish_write();
  endtask

  task automatic do_read();
    int which;
    obs_q.delete();
    set_ar();
    axi.ar_valid = 1'b1;
    addr_phase(which);
    check_eq("ar_accept", which, 2);
    pref_rd = 1'b0;
    if (which == 2) finish_read();
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"}, {axi.aw_ready, axi.ar_ready, axi.w_ready, axi.b_valid,
                             axi.r_valid, mem_req, mem_we, axi.r_last}, 0);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_wr"}, {mem_be, mem_wdata}, 0);
    check_eq({tag, "_r_data"}, axi.r_data, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    pref_rd = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int which;
    int rc0;
    int r;
    axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.b_ready = 0;
    axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0;
    axi.r_ready = 0;
    t_err_beat = -1;
    repeat (3) begin @(posedge clk); #1; end
    check_idle("reset");
    rst = 1'b0;

    // contested AW/AR from reset: write first, then strict alternation
    t_len = 0; t_size = 3; t_burst = 2'b01; t_addr = 48'h200; t_id = 6'h11;
    for (int round = 0; round < 2; round++) begin
      prep_wdata();
      set_aw(); set_ar();
      axi.aw_valid = 1'b1; axi.ar_valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        obs_q.delete();
        addr_phase(which);
        check_eq("arb_order", which, (k == 0) ? 1 : 2);
        pref_rd = (which == 1);
        if (which == 1) finish_write();
        else if (which == 2) finish_read();
      end
    end

    // single-beat write with partial strobes
    t_id = 6'h05; t_addr = 48'h1000_0008; t_len = 0; t_size = 3; t_burst = 2'b01;
    prep_wdata(); t_strb[0] = 8'hF0;
    do_write();

    // narrow INCR read spanning word boundaries, fixed memory latency
    lat_fixed = 2;
    t_id = 6'h2A; t_addr = 48'h4; t_len = 3; t_size = 2; t_burst = 2'b01;
    do_read();
    lat_fixed = 0;

    // WRAP read never reaches memory
    rc0 = req_cycles;
    t_id = 6'h07; t_addr = 48'h80; t_len = 1; t_size = 3; t_burst = 2'b10;
    do_read();
    check_eq("wrap_req_cycles", req_cycles - rc0, 0);

    // early w_last still takes all awlen+1 beats
    t_id = 6'h09; t_addr = 48'h300; t_len = 2; t_size = 3; t_burst = 2'b01; t_err_beat = 1;
    prep_wdata();
    do_write();
    t_err_beat = -1;

    // reset while waiting on read data
    lat_fixed = 3; gnt_pct = 100;
    t_id = 6'h0C; t_addr = 48'h40; t_len = 0; t_size = 3; t_burst = 2'b01;
    obs_q.delete();
    set_ar();
    axi.ar_valid = 1'b1;
    addr_phase(which);
    check_eq("ar_accept_rst", which, 2);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (obs_q.size() > 0) break;
    end
    check_eq("rst_grant_seen", obs_q.size(), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle("rst_rdwait");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pref_rd = 1'b0;
    lat_fixed = 0; gnt_pct = 70;
    t_id = 6'h0D; t_addr = 48'h48; t_len = 1;
    do_read();

    // randomised mix of bursts
    for (int n = 0; n < 40; n++) begin
      gnt_pct = $urandom_range(40, 100);
      t_id    = IW'($urandom());
      t_len   = 8'($urandom_range(0, 7));
      t_size  = 3'($urandom_range(0, 3));
      r       = $urandom_range(0, 9);
      t_burst = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      t_addr  = (n % 8 == 7) ? 48'hFFFF_FFFF_FFF0 : AW'($urandom_range(0, 1023));
      t_err_beat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(t_len))) : -1;
      if ($urandom_range(0, 1) == 1) begin
        prep_wdata();
        do_write();
      end else begin
        do_read();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cluster_axi_to_mem.md
CLUSTER_AXI_TO_MEM -- requirements
Module: cluster_axi_to_mem

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 48, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, AXI and memory data width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 6, AXI ID width (crossbar master-side ID).
REQ-004 SHALL have parameter AXI_USER_WIDTH, default 10, AXI user width.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have port axi_slave, AXI_BUS.Slave, parameterised widths, AXI responder port.
REQ-008 SHALL have port mem_req_o, output, 1, memory request.
REQ-009 SHALL have port mem_gnt_i, input, 1, memory grant; a request is accepted when mem_req_o and mem_gnt_i are both high.
REQ-010 SHALL have port mem_addr_o, output, AXI_ADDR_WIDTH, word-aligned byte address.
REQ-011 SHALL have port mem_we_o, output, 1, write enable.
REQ-012 SHALL have port mem_be_o, output, AXI_DATA_WIDTH/8, byte enables.
REQ-013 SHALL have port mem_wdata_o, output, AXI_DATA_WIDTH, write data.
REQ-014 SHALL have port mem_rvalid_i, input, 1, read data valid, at least 1 cycle after grant.
REQ-015 SHALL have port mem_rdata_i, input, AXI_DATA_WIDTH, read data.

Function
REQ-016 SHALL implement FSM states IDLE, WR_DATA, WR_RESP, RD_REQ, RD_WAIT and RD_RESP, with one transaction in flight at a time.
REQ-017 In IDLE with only aw_valid, SHALL assert aw_ready for one cycle, latch id/addr/len/size/burst, and go to WR_DATA; with only ar_valid, the same on AR and go to RD_REQ.
REQ-018 With aw_valid and ar_valid both high in IDLE, SHALL grant the channel not granted last; after reset, write SHALL be preferred.
REQ-019 Beat address: FIXED keeps the latched address; INCR adds 2^size per beat, and the AXI_ADDR_WIDTH arithmetic wraps modulo 2^AXI_ADDR_WIDTH.
REQ-020 mem_addr_o SHALL be the beat address with its log2(AXI_DATA_WIDTH/8) LSBs zeroed.
REQ-021 WRAP or reserved burst: no memory access; data beats consumed/returned normally; resp = SLVERR (2'b10).
REQ-022 A beat counter SHALL count from 0 to len; the beat at counter == len is last.
REQ-023 In WR_DATA: mem_req_o = w_valid, mem_we_o = 1, mem_be_o = w_strb, mem_wdata_o = w_data, and w_ready = mem_gnt_i (WRAP case: w_ready = 1, mem_req_o = 0).
REQ-024 After the last W handshake, SHALL go to WR_RESP with b_valid = 1, b_id = the latched id and b_user = 0, and hold until b_ready, then return to IDLE.
REQ-025 If w_last differs from (counter == len) on any beat, b_resp SHALL be SLVERR, otherwise OKAY; the beat count always follows awlen.
REQ-026 In RD_REQ, mem_req_o = 1 and mem_we_o = 0; on grant go to RD_WAIT, and on mem_rvalid_i capture mem_rdata_i and go to RD_RESP.
REQ-027 In RD_RESP: r_valid = 1, r_data = captured data, r_id = latched id, r_last = (counter == len), r_resp = OKAY/SLVERR, r_user = 0.
REQ-028 On r_ready in RD_RESP, SHALL go to IDLE if last, else increment the counter and address and go to RD_REQ (WRAP case: skip memory and stay in RD_RESP).
REQ-029 Valid outputs SHALL hold stable with constant payload until their handshake completes.
REQ-030 mem_rvalid_i outside RD_WAIT SHALL be ignored.

Reset
REQ-031 While rst_i is high at a clock edge: state = IDLE; aw_ready, w_ready, ar_ready, b_valid, r_valid and mem_req_o = 0; counters, latched fields and the priority flag = 0.
REQ-032 Reset mid-transaction SHALL abandon it with no further B/R beats or memory requests; the next cycle behaves as after power-up.

Verification
REQ-033 Single write: AW addr 0x1000_0008, len 0, size 3, INCR, strb 0xF0 -> one memory write at 0x1000_0008 with be 0xF0; B OKAY with matching id.
REQ-034 INCR read len 3, size 2, addr 0x04, memory latency 2 -> mem_addr sequence 0x00, 0x08, 0x08, 0x10; 4 R beats, r_last on the 4th only.
REQ-035 aw_valid and ar_valid together from reset, repeated -> order W, R, W, R.
REQ-036 WRAP read len 1 -> 2 R beats with SLVERR and zero mem_req_o cycles.
REQ-037 Write len 2 with w_last on beat 1 -> 3 memory writes; b_resp SLVERR.
REQ-038 rst_i asserted during RD_WAIT -> all outputs 0 next cycle; a following read completes correctly.
